// File: rtl/gray_ptr_pkg.sv
// Shared Gray-pointer helpers and synchronizer limits for the async FIFO pointer logic.
package gray_ptr_pkg;

    // Legal synchronizer depths.
    localparam int unsigned STAGES_MIN = 2;
    localparam int unsigned STAGES_MAX = 4;

    // Widest pointer the helpers handle; callers zero-extend and truncate.
    localparam int unsigned PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Binary to Gray.
    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchronizer: STAGES back-to-back flops, no logic between stages.
module sync_chain
    import gray_ptr_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("sync_chain: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
    end

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the foreign-domain sample through the chain; reset clears in-flight samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Gray pointer synchronizer: brings a foreign-domain Gray pointer across, converts it to
// binary and reports the per-sample advance, a change pulse and a sticky illegal-step flag.
module gray_ptr_sync
    import gray_ptr_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [WIDTH:0] d_in,
    input  logic           err_clr,
    output logic [WIDTH:0] d_out,
    output logic [WIDTH:0] bin_out,
    output logic [WIDTH:0] delta,
    output logic           chg,
    output logic           err
);

    localparam int unsigned PTR_W = WIDTH + 1;
    // Largest legal advance per sample: one full FIFO depth.
    localparam logic [PTR_W-1:0] MAX_STEP = {1'b1, {WIDTH{1'b0}}};

    if (WIDTH < 1 || PTR_W > PTR_MAX_W) begin : g_bad_width
        $error("gray_ptr_sync: WIDTH=%0d unsupported", WIDTH);
    end

    logic [PTR_W-1:0] d_sync;
    logic [PTR_W-1:0] d_prev_q;
    logic [PTR_W-1:0] bin_cur;
    logic [PTR_W-1:0] bin_prev;
    logic [PTR_W-1:0] delta_d;
    logic             chg_d;
    logic             viol;
    logic             err_d;

    logic [PTR_W-1:0] bin_q;
    logic [PTR_W-1:0] delta_q;
    logic             chg_q;
    logic             err_q;

    sync_chain #(
        .WIDTH  (PTR_W),
        .STAGES (STAGES)
    ) u_sync_chain (
        .clk (clk),
        .rst (rst),
        .d   (d_in),
        .q   (d_sync)
    );

    // Remember the previous synchronized sample to detect movement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_prev_q <= '0;
        end else begin
            d_prev_q <= d_sync;
        end
    end

    // Binary view of current and previous samples, advance and violation detection.
    always_comb begin
        bin_cur  = PTR_W'(gray2bin(ptr_word_t'(d_sync)));
        bin_prev = PTR_W'(gray2bin(ptr_word_t'(d_prev_q)));
        chg_d    = (d_sync != d_prev_q);
        delta_d  = '0;
        if (chg_d) begin
            // Modulo subtraction makes the top-to-zero wrap a normal +1 step.
            delta_d = bin_cur - bin_prev;
        end
        // Backward moves alias to large advances, so one compare catches both.
        viol  = (delta_d > MAX_STEP);
        // A new violation overrides a clear in the same cycle.
        err_d = viol | (err_q & ~err_clr);
    end

    // Register the decoded outputs so bin_out, delta, chg and err line up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q   <= '0;
            delta_q <= '0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            bin_q   <= bin_cur;
            delta_q <= delta_d;
            chg_q   <= chg_d;
            err_q   <= err_d;
        end
    end

    assign d_out   = d_sync;
    assign bin_out = bin_q;
    assign delta   = delta_q;
    assign chg     = chg_q;
    assign err     = err_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync: three depths (2, 3, 4) driven with the same directed stimulus,
// checked every cycle against a sample-history model plus hand-computed literal checks.
module tb_gray_ptr_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr = 1'b0;
    logic [4:0] d_in = 5'd0;

    logic [4:0] d_out_a [2:4];
    logic [4:0] bin_a   [2:4];
    logic [4:0] delta_a [2:4];
    logic       chg_a   [2:4];
    logic       err_a   [2:4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_ptr_sync #(.WIDTH(4), .STAGES(2)) u_s2 (
        .clk(clk), .rst(rst), .d_in(d_in), .err_clr(err_clr),
        .d_out(d_out_a[2]), .bin_out(bin_a[2]), .delta(delta_a[2]), .chg(chg_a[2]),
        .err(err_a[2])
    );
    gray_ptr_sync #(.WIDTH(4), .STAGES(3)) u_s3 (
        .clk(clk), .rst(rst), .d_in(d_in), .err_clr(err_clr),
        .d_out(d_out_a[3]), .bin_out(bin_a[3]), .delta(delta_a[3]), .chg(chg_a[3]),
        .err(err_a[3])
    );
    gray_ptr_sync #(.WIDTH(4), .STAGES(4)) u_s4 (
        .clk(clk), .rst(rst), .d_in(d_in), .err_clr(err_clr),
        .d_out(d_out_a[4]), .bin_out(bin_a[4]), .delta(delta_a[4]), .chg(chg_a[4]),
        .err(err_a[4])
    );

    // ---------------- model ----------------
    logic [4:0] hist [$];     // d_in as seen at each clock edge since reset, newest last
    logic       err_m [2:4];

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        for (int i = 0; i < 5; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Sample taken j edges before the newest one; zero before reset release.
    function automatic logic [4:0] at(input int j);
        if (j < hist.size()) return hist[hist.size() - 1 - j];
        return 5'd0;
    endfunction

    function automatic logic [4:0] exp_delta(input int s);
        return g2b(at(s)) - g2b(at(s + 1));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            for (int s = 2; s <= 4; s++) err_m[s] = 1'b0;
        end else begin
            hist.push_back(d_in);
            if (hist.size() > 8) void'(hist.pop_front());
            for (int s = 2; s <= 4; s++)
                err_m[s] = (exp_delta(s) > 5'd16) | (err_m[s] & ~err_clr);
        end
    end

    task automatic check5(input string name, input int s, input logic [4:0] act,
                          input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s STAGES=%0d actual=%0d required=%0d t=%0t", name, s, act, exp,
                     $time);
        end
    endtask

    task automatic check1(input string name, input int s, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s STAGES=%0d actual=%0b required=%0b t=%0t", name, s, act, exp,
                     $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            for (int s = 2; s <= 4; s++) begin
                check5("model_d_out", s, d_out_a[s], at(s - 1));
                check5("model_bin_out", s, bin_a[s], g2b(at(s)));
                check5("model_delta", s, delta_a[s], exp_delta(s));
                check1("model_chg", s, chg_a[s], at(s) != at(s + 1));
                check1("model_err", s, err_a[s], err_m[s]);
            end
        end
    end

    // Move to binary pointer b and watch long enough for every depth to report it.
    task automatic step(input logic [4:0] b, input logic [4:0] exp_d, input logic exp_err);
        int         pulses [2:4];
        logic [4:0] seen   [2:4];
        for (int s = 2; s <= 4; s++) begin
            pulses[s] = 0;
            seen[s]   = 5'd0;
        end
        d_in = b2g(b);
        repeat (7) begin
            @(negedge clk);
            for (int s = 2; s <= 4; s++) begin
                if (chg_a[s]) begin
                    pulses[s]++;
                    seen[s] = delta_a[s];
                end
            end
        end
        for (int s = 2; s <= 4; s++) begin
            check5("step_pulses", s, 5'(pulses[s]), 5'd1);
            check5("step_delta", s, seen[s], exp_d);
            check5("step_bin", s, bin_a[s], b);
            check1("step_err", s, err_a[s], exp_err);
        end
    endtask

    // Fixed per-cycle advances for a fast-source walk (all legal).
    localparam int NWALK = 12;
    int walk_inc [NWALK] = '{1, 3, 0, 2, 2, 1, 0, 3, 1, 1, 2, 3};

    initial begin
        logic [4:0] cur;
        int         pulses [2:4];

        // Reset state.
        repeat (3) @(negedge clk);
        for (int s = 2; s <= 4; s++) begin
            check5("rst_d_out", s, d_out_a[s], 5'd0);
            check5("rst_bin", s, bin_a[s], 5'd0);
            check5("rst_delta", s, delta_a[s], 5'd0);
            check1("rst_chg", s, chg_a[s], 1'b0);
            check1("rst_err", s, err_a[s], 1'b0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Latency: change at cycle 0, d_out after STAGES edges, bin/delta/chg one later.
        d_in = 5'b00001;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            for (int s = 2; s <= 4; s++) begin
                check5("lat_d_out", s, d_out_a[s], (n >= s) ? 5'd1 : 5'd0);
                check5("lat_bin", s, bin_a[s], (n >= s + 1) ? 5'd1 : 5'd0);
                check1("lat_chg", s, chg_a[s], n == s + 1);
                if (n == s + 1) check5("lat_delta", s, delta_a[s], 5'd1);
            end
        end

        // Climb to 30, then wrap through 31 -> 0.
        step(5'd16, 5'd15, 1'b0);
        step(5'd30, 5'd14, 1'b0);
        step(5'd31, 5'd1, 1'b0);
        step(5'd0, 5'd1, 1'b0);
        for (int s = 2; s <= 4; s++) check5("wrap_end_bin", s, bin_a[s], 5'd0);

        // Fast source jump, then a backward step.
        step(5'd2, 5'd2, 1'b0);
        step(5'd6, 5'd4, 1'b0);
        step(5'd5, 5'd31, 1'b1);

        // Clear with no violation.
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        for (int s = 2; s <= 4; s++) check1("clr_err", s, err_a[s], 1'b0);

        // Backward again sets err; then clear coincident with a violation on STAGES=2.
        step(5'd2, 5'd29, 1'b1);
        d_in = b2g(5'd0);
        repeat (2) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check1("clr_vs_viol_err", 2, err_a[2], 1'b1);
        check5("clr_vs_viol_delta", 2, delta_a[2], 5'd30);
        repeat (6) @(negedge clk);
        for (int s = 2; s <= 4; s++) check1("clr_vs_viol_sticky", s, err_a[s], 1'b1);

        // Clear, then a fast walk with a new value almost every cycle.
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        cur = 5'd0;
        for (int i = 0; i < NWALK; i++) begin
            cur  = cur + 5'(walk_inc[i]);
            d_in = b2g(cur);
            @(negedge clk);
        end

        // Reset mid-stream, asynchronous to clk.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int s = 2; s <= 4; s++) begin
            check5("async_rst_d_out", s, d_out_a[s], 5'd0);
            check5("async_rst_bin", s, bin_a[s], 5'd0);
            check5("async_rst_delta", s, delta_a[s], 5'd0);
            check1("async_rst_chg", s, chg_a[s], 1'b0);
            check1("async_rst_err", s, err_a[s], 1'b0);
        end
        @(negedge clk);
        d_in = 5'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int s = 2; s <= 4; s++) pulses[s] = 0;
        repeat (10) begin
            @(negedge clk);
            for (int s = 2; s <= 4; s++) if (chg_a[s]) pulses[s]++;
        end
        for (int s = 2; s <= 4; s++) check5("post_rst_pulses", s, 5'(pulses[s]), 5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_ptr_sync.md
GRAY_PTR_SYNC -- requirements
Module: gray_ptr_sync

Interface
REQ-001 SHALL provide parameter WIDTH, default 4: FIFO address bits; pointer width is WIDTH+1.
REQ-002 SHALL provide parameter STAGES, default 2: synchronizer flop depth; legal 2..4; any other value SHALL fail elaboration.
REQ-003 SHALL provide port clk, input, 1: destination-domain clock, rising edge.
REQ-004 SHALL provide port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL provide port d_in, input, WIDTH+1: Gray-coded pointer from the foreign clock domain.
REQ-006 SHALL provide port err_clr, input, 1: synchronous clear of err.
REQ-007 SHALL provide port d_out, output, WIDTH+1: synchronized Gray pointer.
REQ-008 SHALL provide port bin_out, output, WIDTH+1: binary equivalent of d_out, registered.
REQ-009 SHALL provide port delta, output, WIDTH+1: pointer advance since previous sample, modulo 2^(WIDTH+1).
REQ-010 SHALL provide port chg, output, 1: one-cycle pulse when bin_out takes a new value.
REQ-011 SHALL provide port err, output, 1: sticky flag, set on an illegal pointer step.

Function
REQ-012 SHALL pass d_in through a chain of STAGES flops with no logic between stages; d_out = last stage; latency STAGES cycles.
REQ-013 SHALL hold d_prev = d_out delayed by one clk.
REQ-014 SHALL register bin_out <= gray2bin(d_out) every cycle; latency d_in->bin_out is STAGES+1 cycles.
REQ-015 SHALL register delta <= (gray2bin(d_out) - gray2bin(d_prev)) mod 2^(WIDTH+1), in the same cycle as bin_out.
REQ-016 SHALL assert chg for exactly one cycle, aligned with bin_out/delta, when d_out != d_prev; otherwise chg=0 and delta=0.
REQ-017 SHALL treat wrap-around as a normal step: binary 2^(WIDTH+1)-1 -> 0 gives delta=1, err not set.
REQ-018 SHALL set err when the registered delta exceeds 2^WIDTH, i.e. the pointer moved backward or advanced more than FIFO depth.
REQ-019 SHALL hold err until a cycle with err_clr=1 and no new violation; a violation in the same cycle as err_clr keeps err=1 (set wins).
REQ-020 SHALL allow the source to advance several counts between destination edges: multi-count delta up to 2^WIDTH is legal.

Reset
REQ-021 SHALL asynchronously force all chain stages, d_prev, d_out, bin_out and delta to 0, and chg and err to 0, while rst=1.
REQ-022 SHALL, after rst deasserts, produce no chg pulse until d_in differs from 0 and has propagated STAGES cycles.
REQ-023 SHALL apply reset mid-operation immediately, discarding in-flight samples; rst deassertion is synchronized to clk by the integrator.

Structure
REQ-024 SHALL take the gray2bin/bin2gray functions and the constants STAGES_MIN=2 and STAGES_MAX=4 from shared package gray_ptr_pkg; the async FIFO pointer logic SHALL use the same package.
REQ-025 SHALL build the flop chain as one sub-module, sync_chain (parameters WIDTH, STAGES), reused for single-bit synchronization elsewhere.

Verification
REQ-026 SHALL cover latency: WIDTH=4, STAGES=2, d_in 00000->00001 at cycle 0 -> d_out=00001 at cycle 2; bin_out=1, delta=1, chg=1 at cycle 3; chg=0 at cycle 4.
REQ-027 SHALL cover wrap: d_in steps Gray 10001 (bin 30) -> 10000 (bin 31) -> 00000 (bin 0) -> delta=1 on each step, err=0, bin_out ends at 0.
REQ-028 SHALL cover fast source: d_in jumps bin 2 -> bin 6 between edges -> one chg pulse, delta=4, err=0; backward step bin 6 -> 5 -> delta=31, err=1.
REQ-029 SHALL cover clear priority: err=1, err_clr=1 with no violation -> err=0 next cycle; err_clr=1 coincident with a violation -> err stays 1.
REQ-030 SHALL cover reset: rst asserted mid-stream, asynchronous to clk -> all outputs 0 within the same cycle; after release with d_in=0 -> no chg pulse.
REQ-031 SHALL cover depth sweep: repeat REQ-026 with STAGES=3 and 4 -> bin_out latency 4 and 5 cycles; STAGES=5 -> elaboration error.
